// File: rtl/mei_controller_pkg.sv
// Shared constants and helpers for the machine external interrupt controller.
// Register word indices, claim ID encoding and byte-lane write merge.
package mei_controller_pkg;

  localparam int unsigned MEI_ID_WIDTH = 5;
  localparam int unsigned MEI_BUS_W    = 32;
  localparam int unsigned MEI_LANES    = 4;

  localparam logic [MEI_ID_WIDTH-1:0] MEI_ID_NONE = '0;

  typedef enum logic [1:0] {
    MEI_REG_PENDING = 2'd0,
    MEI_REG_ENABLE  = 2'd1,
    MEI_REG_CLAIM   = 2'd2,
    MEI_REG_EDGE    = 2'd3
  } mei_reg_e;

  // Replace only the bytes whose write enable is set.
  function automatic logic [MEI_BUS_W-1:0] lane_merge(
    input logic [MEI_BUS_W-1:0] old_v,
    input logic [MEI_BUS_W-1:0] new_v,
    input logic [MEI_LANES-1:0] be
  );
    logic [MEI_BUS_W-1:0] res;
    res = old_v;
    for (int b = 0; b < int'(MEI_LANES); b++) begin
      if (be[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mei_gateway.sv
// Per-source interrupt gateway: 2-flop synchronizer, optional edge detect
// (MEI_EDGE_EN), pending latch and in-service flag.
module mei_gateway (
  input  logic clk,
  input  logic rst_n,
  input  logic irq_i,
  input  logic mode_edge,
  input  logic claim_i,
  input  logic complete_i,
  output logic pending_o,
  output logic in_service_o
);

  logic sync1_q;
  logic sync2_q;
  logic pending_q;
  logic pending_d;
  logic in_service_q;
  logic in_service_d;
  logic trig;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= irq_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef MEI_EDGE_EN
  logic prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= sync2_q;
  end

  assign trig = mode_edge ? (sync2_q & ~prev_q) : sync2_q;
`else
  logic unused_mode;

  assign unused_mode = mode_edge;
  assign trig        = sync2_q;
`endif

  // Claim beats a same-cycle gateway set; the gateway sees the old in_service.
  always_comb begin
    pending_d    = pending_q;
    in_service_d = in_service_q;
    if (claim_i) begin
      pending_d    = 1'b0;
      in_service_d = 1'b1;
    end else begin
      if (trig && !pending_q && !in_service_q) pending_d = 1'b1;
      if (complete_i) in_service_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q    <= 1'b0;
      in_service_q <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
    end
  end

  assign pending_o    = pending_q;
  assign in_service_o = in_service_q;

endmodule

// File: rtl/mei_controller.sv
// Machine external interrupt controller: per-source gateways, enable mask,
// fixed-priority claim/complete. Edge-triggered mode is built with MEI_EDGE_EN.
module mei_controller
  import mei_controller_pkg::*;
#(
  parameter int unsigned MEI_PORTS = 4,
  parameter int unsigned XLEN      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [MEI_PORTS-1:0] irq_src,
  input  logic                 sel,
  input  logic                 ren,
  input  logic [3:0]           addr,
  input  logic [XLEN-1:0]      wdata,
  input  logic [3:0]           wenable,
  output logic [XLEN-1:0]      rdata,
  output logic                 mei_pending
);

  mei_reg_e                reg_idx;
  logic [MEI_PORTS-1:0]    pending;
  logic [MEI_PORTS-1:0]    in_service;
  logic [MEI_PORTS-1:0]    enable_q;
  logic [MEI_PORTS-1:0]    enable_d;
  logic [MEI_PORTS-1:0]    edge_mode;
  logic [MEI_PORTS-1:0]    claim_vec;
  logic [MEI_PORTS-1:0]    complete_vec;
  logic [MEI_ID_WIDTH-1:0] claim_id;
  logic [MEI_ID_WIDTH-1:0] complete_id;
  logic                    claim_fire;
  logic                    complete_fire;
  logic                    unused_sig;

  assign reg_idx     = mei_reg_e'(addr[3:2]);
  assign complete_id = wdata[MEI_ID_WIDTH-1:0];
  assign unused_sig  = ^{addr[1:0], in_service};

  for (genvar g = 0; g < int'(MEI_PORTS); g++) begin : g_gw
    mei_gateway u_gw (
      .clk          (clk),
      .rst_n        (rst_n),
      .irq_i        (irq_src[g]),
      .mode_edge    (edge_mode[g]),
      .claim_i      (claim_vec[g]),
      .complete_i   (complete_vec[g]),
      .pending_o    (pending[g]),
      .in_service_o (in_service[g])
    );
  end

  // Fixed priority: lowest source index wins.
  always_comb begin
    claim_id = MEI_ID_NONE;
    for (int i = int'(MEI_PORTS) - 1; i >= 0; i--) begin
      if (pending[i] && enable_q[i]) claim_id = MEI_ID_WIDTH'(i + 1);
    end
  end

  assign claim_fire    = sel && ren && (reg_idx == MEI_REG_CLAIM) && (claim_id != MEI_ID_NONE);
  assign complete_fire = sel && (reg_idx == MEI_REG_CLAIM) && wenable[0];

  // Out-of-range complete IDs match no source and fall out naturally.
  always_comb begin
    claim_vec    = '0;
    complete_vec = '0;
    for (int i = 0; i < int'(MEI_PORTS); i++) begin
      claim_vec[i]    = claim_fire && (claim_id == MEI_ID_WIDTH'(i + 1));
      complete_vec[i] = complete_fire && (complete_id == MEI_ID_WIDTH'(i + 1));
    end
  end

  always_comb begin
    enable_d = enable_q;
    if (sel && (reg_idx == MEI_REG_ENABLE)) begin
      enable_d = MEI_PORTS'(lane_merge(MEI_BUS_W'(enable_q), MEI_BUS_W'(wdata), wenable));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) enable_q <= '0;
    else        enable_q <= enable_d;
  end

`ifdef MEI_EDGE_EN
  logic [MEI_PORTS-1:0] edge_q;
  logic [MEI_PORTS-1:0] edge_d;

  always_comb begin
    edge_d = edge_q;
    if (sel && (reg_idx == MEI_REG_EDGE)) begin
      edge_d = MEI_PORTS'(lane_merge(MEI_BUS_W'(edge_q), MEI_BUS_W'(wdata), wenable));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) edge_q <= '0;
    else        edge_q <= edge_d;
  end

  assign edge_mode = edge_q;
`else
  assign edge_mode = '0;
`endif

  // Single-cycle read path matching the CPU load stage.
  always_comb begin
    rdata = '0;
    if (sel) begin
      case (reg_idx)
        MEI_REG_PENDING: rdata = XLEN'(pending);
        MEI_REG_ENABLE:  rdata = XLEN'(enable_q);
        MEI_REG_CLAIM:   rdata = XLEN'(claim_id);
`ifdef MEI_EDGE_EN
        MEI_REG_EDGE:    rdata = XLEN'(edge_q);
`else
        MEI_REG_EDGE:    rdata = '0;
`endif
        default:         rdata = '0;
      endcase
    end
  end

  assign mei_pending = |(pending & enable_q);

endmodule

// File: tb/tb_mei_controller.sv
// Directed self-checking bench for mei_controller (default 4 sources, 32-bit bus).
module tb_mei_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  irq_src;
  logic        sel;
  logic        ren;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  wenable;
  logic [31:0] rdata;
  logic        mei_pending;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  logic [31:0] d;

  always #5 clk = ~clk;

  mei_controller #(.MEI_PORTS(4), .XLEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .irq_src     (irq_src),
    .sel         (sel),
    .ren         (ren),
    .addr        (addr),
    .wdata       (wdata),
    .wenable     (wenable),
    .rdata       (rdata),
    .mei_pending (mei_pending)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Side-effect-free read (ren=0), no clock consumed.
  task automatic peek(input logic [1:0] idx, output logic [31:0] v);
    sel = 1'b1; ren = 1'b0; wenable = 4'h0; addr = {idx, 2'b00};
    #1 v = rdata;
    sel = 1'b0;
  endtask

  task automatic claim(output logic [31:0] v);
    sel = 1'b1; ren = 1'b1; wenable = 4'h0; addr = 4'h8;
    #1 v = rdata;
    @(posedge clk); #1;
    sel = 1'b0; ren = 1'b0;
  endtask

  task automatic wr(input logic [1:0] idx, input logic [31:0] data, input logic [3:0] be);
    sel = 1'b1; ren = 1'b0; addr = {idx, 2'b00}; wdata = data; wenable = be;
    @(posedge clk); #1;
    sel = 1'b0; wenable = 4'h0;
  endtask

  initial begin
    rst_n = 1'b0; irq_src = 4'h0; sel = 1'b0; ren = 1'b0;
    addr = 4'h0; wdata = 32'h0; wenable = 4'h0;
    step(2);
    rst_n = 1'b1;
    step(1);

    // Reset then idle
    chk("rst_mei_pending", {31'b0, mei_pending}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      peek(2'(i), d);
      chk("rst_read_idx", d, 32'h0);
    end
    sel = 1'b0; addr = 4'h4; #1;
    chk("unsel_rdata", rdata, 32'h0);

    // Basic claim / complete with level held
    wr(2'd1, 32'h4, 4'b0001);
    peek(2'd1, d); chk("enable_rd", d, 32'h4);
    irq_src[2] = 1'b1;
    step(2); chk("lat_edge2", {31'b0, mei_pending}, 32'h0);
    step(1); chk("lat_edge3", {31'b0, mei_pending}, 32'h1);
    peek(2'd0, d); chk("pending_src2", d, 32'h4);
    claim(d); chk("claim_3", d, 32'h3);
    chk("mp_after_claim", {31'b0, mei_pending}, 32'h0);
    peek(2'd0, d); chk("pending_cleared", d, 32'h0);
    wr(2'd2, 32'h3, 4'b0001);
    chk("complete_same_cyc", {31'b0, mei_pending}, 32'h0);
    step(1);
    chk("repend_next_cyc", {31'b0, mei_pending}, 32'h1);
    irq_src[2] = 1'b0;
    step(3); chk("pending_latched", {31'b0, mei_pending}, 32'h1);
    claim(d); chk("claim_3_again", d, 32'h3);
    wr(2'd2, 32'h3, 4'b0001);
    step(2); peek(2'd0, d); chk("basic_idle", d, 32'h0);

    // Priority
    wr(2'd1, 32'hF, 4'b0001);
    irq_src[1] = 1'b1; irq_src[3] = 1'b1;
    step(3); peek(2'd0, d); chk("prio_pending", d, 32'hA);
    claim(d); chk("prio_claim_2", d, 32'h2);
    irq_src[1] = 1'b0;
    claim(d); chk("prio_claim_4", d, 32'h4);
    claim(d); chk("prio_claim_none", d, 32'h0);
    wr(2'd2, 32'h2, 4'b0001);
    step(2); peek(2'd0, d); chk("no_repend_low", d, 32'h0);
    wr(2'd2, 32'h4, 4'b0001);
    step(1); peek(2'd0, d); chk("repend_src3", d, 32'h8);
    irq_src[1] = 1'b1;
    step(3); peek(2'd0, d); chk("src1_free_again", d, 32'hA);
    irq_src[1] = 1'b0; irq_src[3] = 1'b0;
    claim(d); chk("cleanup_claim_2", d, 32'h2);
    claim(d); chk("cleanup_claim_4", d, 32'h4);
    wr(2'd2, 32'h2, 4'b0001);
    wr(2'd2, 32'h4, 4'b0001);
    step(3); peek(2'd0, d); chk("prio_idle", d, 32'h0);

    // Masking, byte lanes, no-ren read
    wr(2'd1, 32'h0, 4'b0001);
    irq_src[0] = 1'b1;
    step(3); chk("masked_mp", {31'b0, mei_pending}, 32'h0);
    peek(2'd0, d); chk("masked_pending", d, 32'h1);
    peek(2'd2, d); chk("masked_claim_id", d, 32'h0);
    wr(2'd1, 32'hF, 4'b1110);
    peek(2'd1, d); chk("lane_ignored", d, 32'h0);
    sel = 1'b1; addr = 4'h4; wdata = 32'h1; wenable = 4'b0001;
    @(posedge clk); #1;
    chk("enable_immediate", {31'b0, mei_pending}, 32'h1);
    sel = 1'b0; wenable = 4'h0;
    sel = 1'b1; ren = 1'b0; addr = 4'h8; #1;
    chk("noren_rdata", rdata, 32'h1);
    step(1); sel = 1'b0;
    peek(2'd0, d); chk("noren_no_effect", d, 32'h1);
    wr(2'd0, 32'h0, 4'hF);
    peek(2'd0, d); chk("pending_ro", d, 32'h1);
    wr(2'd3, 32'hF, 4'b0001);
    peek(2'd3, d);
`ifdef MEI_EDGE_EN
    chk("edge_rw", d, 32'hF);
    wr(2'd3, 32'h0, 4'b0001);
`else
    chk("edge_reads_0", d, 32'h0);
`endif

    // Bad completes while source 0 in service with level held
    claim(d); chk("claim_1", d, 32'h1);
    wr(2'd2, 32'h0, 4'b0001); step(1); peek(2'd0, d); chk("bad_id0", d, 32'h0);
    wr(2'd2, 32'h7, 4'b0001); step(1); peek(2'd0, d); chk("bad_id7", d, 32'h0);
    wr(2'd2, 32'h2, 4'b0001); step(1); peek(2'd0, d); chk("bad_not_insvc", d, 32'h0);
    wr(2'd2, 32'h1, 4'b0010); step(1); peek(2'd0, d); chk("bad_lane0_off", d, 32'h0);

    // Reset mid-claim
    rst_n = 1'b0; step(1); rst_n = 1'b1;
    peek(2'd0, d); chk("rst_pending", d, 32'h0);
    peek(2'd1, d); chk("rst_enable", d, 32'h0);
    step(2); peek(2'd0, d); chk("rst_sync_lat", d, 32'h0);
    step(1); peek(2'd0, d); chk("rst_repend", d, 32'h1);
    chk("rst_masked_mp", {31'b0, mei_pending}, 32'h0);
    wr(2'd1, 32'h1, 4'b0001);
    chk("rst_enable_mp", {31'b0, mei_pending}, 32'h1);
    claim(d); chk("rst_claim_1", d, 32'h1);
    irq_src[0] = 1'b0;
    step(3);
    wr(2'd2, 32'h1, 4'b0001);
    step(3); peek(2'd0, d); chk("final_idle", d, 32'h0);

`ifdef MEI_EDGE_EN
    // Edge-triggered source 0
    wr(2'd3, 32'h1, 4'b0001);
    irq_src[0] = 1'b1; step(1); irq_src[0] = 1'b0;
    step(2); peek(2'd0, d); chk("edge_pulse_pend", d, 32'h1);
    claim(d); chk("edge_claim_1", d, 32'h1);
    irq_src[0] = 1'b1;
    step(4);
    wr(2'd2, 32'h1, 4'b0001);
    step(3); peek(2'd0, d); chk("edge_no_level_repend", d, 32'h0);
    irq_src[0] = 1'b0;
    step(3);
    irq_src[0] = 1'b1; step(1); irq_src[0] = 1'b0;
    step(2); peek(2'd0, d); chk("edge_pulse2_pend", d, 32'h1);
    claim(d); chk("edge_claim_again", d, 32'h1);
    irq_src[0] = 1'b1; step(1); irq_src[0] = 1'b0;
    step(3); peek(2'd0, d); chk("edge_dropped_insvc", d, 32'h0);
    wr(2'd2, 32'h1, 4'b0001);
    step(3); peek(2'd0, d); chk("edge_stays_idle", d, 32'h0);
`endif

    chk("end_mp", {31'b0, mei_pending}, 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
